adc_spi_timing_gen: RTL and testbench

- System-clock-domain timing generator that drives SCLK and CS to the serial ADC and to our negedge-SCLK serial receiver directly downstream.
- Produces a free-running SCLK and a CS-low window of a fixed number of falling SCLK edges (one detect edge plus 16 data edges).
- Frames are launched either by a single-shot request or by an internal sample-rate timer.
- Emits clk-domain status strobes (busy, frame_done, overrun) for the capture/control logic.

---
 rtl/adc_spi_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_adc_spi_timing_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_timing_gen.sv
// adc_spi_timing_gen
// Generates a free-running SCLK and a CS-low frame window for a serial ADC
// and its negedge-SCLK receiver. Frames start from a single-shot request or
// from an internal sample-rate timer. The block also emits clk-domain status
// strobes. CS moves only on SCLK rising ticks, so it is stable around every
// falling edge that the receiver uses.
module adc_spi_timing_gen #(
  parameter int DIV_HALF    = 2,     // clk cycles per SCLK half-period, >= 1
  parameter int CS_EDGES    = 17,    // falling SCLK edges inside a frame
  parameter int QUIET_EDGES = 4,     // falling SCLK edges of enforced CS-high, >= 1
  parameter int SAMPLE_DIV  = 2500   // clk cycles between rate-timer requests
) (
  input  logic clk,
  input  logic reset,       // asynchronous, active-low
  input  logic en,
  input  logic start,
  output logic SCLK,
  output logic CS,
  output logic sclk_fall,
  output logic busy,
  output logic frame_done,
  output logic overrun
);

  localparam int DW = (DIV_HALF > 1)   ? $clog2(DIV_HALF)   : 1;
  localparam int EW = $clog2(CS_EDGES + 1);
  localparam int QW = (QUIET_EDGES > 1) ? $clog2(QUIET_EDGES) : 1;
  localparam int RW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_HALF - 1);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(CS_EDGES);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_EDGES - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(SAMPLE_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [DW-1:0] r_div_cnt;
  logic          r_sclk;
  logic          r_sclk_fall;
  logic [RW-1:0] r_rate_cnt;
  logic          r_req;
  logic          r_overrun;
  logic [1:0]    r_state;
  logic          r_cs;
  logic [EW-1:0] r_edge_cnt;
  // q_cnt only has to count up to QUIET_EDGES-1. Leaving QUIET happens on the
  // same fall tick that would push it to QUIET_EDGES.
  logic [QW-1:0] r_q_cnt;
  logic          r_frame_done;

  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_wrap;
  logic w_new_req;
  logic w_launch;
  logic w_frame_end;
  logic w_quiet_end;

  assign w_tick      = (r_div_cnt == DIV_LAST);
  assign w_rise      = w_tick & ~r_sclk;
  assign w_fall      = w_tick &  r_sclk;
  assign w_wrap      = en & (r_rate_cnt == RATE_LAST);
  assign w_new_req   = start | w_wrap;
  assign w_launch    = (r_state == S_IDLE)  & w_rise & r_req;
  assign w_frame_end = (r_state == S_FRAME) & w_rise & (r_edge_cnt == EDGE_LAST);
  // Returning to IDLE on the last quiet fall tick makes the next rise tick a
  // legal launch point. This gives exactly QUIET_EDGES*2*DIV_HALF of CS-high.
  assign w_quiet_end = (r_state == S_QUIET) & w_fall & (r_q_cnt == QUIET_LAST);

  // SCLK divider: free-running in every state, idles high in reset.
  // NOTE: the reset is asynchronous, so it appears in the sensitivity list.
  // State registers use non-blocking assignments, so every block samples
  // pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b1;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Registered strobe marking the cycle in which SCLK has just fallen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sclk_fall <= 1'b0;
    else        r_sclk_fall <= w_fall;
  end

  // Sample-rate timer: held at zero while disabled, wraps every SAMPLE_DIV clks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_rate_cnt <= '0;
    else if (!en)    r_rate_cnt <= '0;
    else if (w_wrap) r_rate_cnt <= '0;
    else             r_rate_cnt <= r_rate_cnt + 1'b1;
  end

  // Single-entry request latch. A launch consumes the pending request. A new
  // request that finds the latch already full is dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_req     <= (r_req & ~w_launch) | w_new_req;
      r_overrun <= w_new_req & r_req & ~w_launch;
    end
  end

  // Frame FSM: owns CS and the frame/quiet edge counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cs         <= 1'b1;
      r_edge_cnt   <= '0;
      r_q_cnt      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs <= 1'b1;
          if (w_launch) begin
            r_cs       <= 1'b0;
            r_edge_cnt <= '0;
            r_state    <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (w_frame_end) begin
            r_cs         <= 1'b1;
            r_frame_done <= 1'b1;
            r_q_cnt      <= '0;
            r_state      <= S_QUIET;
          end else if (w_fall) begin
            r_edge_cnt <= r_edge_cnt + 1'b1;
          end
        end
        S_QUIET: begin
          if (w_quiet_end) begin
            r_state <= S_IDLE;
          end else if (w_fall) begin
            r_q_cnt <= r_q_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cs    <= 1'b1;
        end
      endcase
    end
  end

  assign SCLK       = r_sclk;
  assign CS         = r_cs;
  assign sclk_fall  = r_sclk_fall;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_spi_timing_gen.sv
// tb_adc_spi_timing_gen
// Directed bench for adc_spi_timing_gen. It uses DIV_HALF=2, CS_EDGES=17 and
// QUIET_EDGES=4, with SAMPLE_DIV=100 for continuous mode. A negedge monitor
// collects frame statistics. Directed phases compare those statistics with
// hand-computed constants.
module tb_adc_spi_timing_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  logic start = 1'b0;
  logic SCLK, CS, sclk_fall, busy, frame_done, overrun;

  adc_spi_timing_gen #(
    .DIV_HALF   (2),
    .CS_EDGES   (17),
    .QUIET_EDGES(4),
    .SAMPLE_DIV (100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .SCLK      (SCLK),
    .CS        (CS),
    .sclk_fall (sclk_fall),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state, updated only by the negedge monitor.
  int   cyc = 0;
  int   fall_total = 0, fall_cs_low = 0, last_fall_cyc = 0, last_fall_gap = 0;
  int   done_cnt = 0, bad_done = 0, ovr_cnt = 0, frames = 0;
  int   last_cs_fall = 0, last_cs_rise = 0, low_len = 0, high_gap = 0, fall_gap = 0;
  int   busy_low_after = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;

  // Collect frame statistics away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sclk_fall) begin
      fall_total++;
      if (!CS) fall_cs_low++;
      last_fall_gap = cyc - last_fall_cyc;
      last_fall_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      if (!(CS && !prev_cs)) bad_done++;
    end
    if (!prev_cs && CS && reset && !frame_done) bad_done++;
    if (overrun) ovr_cnt++;
    if (prev_cs && !CS) begin
      frames++;
      fall_gap     = cyc - last_cs_fall;
      high_gap     = cyc - last_cs_rise;
      last_cs_fall = cyc;
    end
    if (!prev_cs && CS) begin
      low_len      = cyc - last_cs_fall;
      last_cs_rise = cyc;
    end
    if (prev_busy && !busy) busy_low_after = cyc - last_cs_rise;
    prev_cs   = CS;
    prev_busy = busy;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Pulse start for exactly one posedge. Returns the monitor cycle just
  // before that edge.
  task automatic pulse_start(output int s_cyc);
    @(negedge clk); #1;
    s_cyc = cyc;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  int s_cyc, f0, d0, fl0, o0, lat;
  bit hit;

  initial begin
    // Reset held for five cycles: SCLK/CS idle high, all strobes low.
    repeat (5) begin
      @(negedge clk); #1;
      check("rst_sclk_cs", {30'd0, SCLK, CS}, 32'd3);
      check("rst_strobes", {28'd0, sclk_fall, busy, frame_done, overrun}, 32'd0);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    // Falls at posedges 2, 6, 10 and 14 after release.
    idle(14);
    check("sclk_fall_count", fall_total, 4);
    check("sclk_period", last_fall_gap, 4);
    check("idle_cs_busy", {30'd0, CS, busy}, 32'd2);

    // Single shot.
    f0 = frames; d0 = done_cnt; fl0 = fall_cs_low; o0 = ovr_cnt;
    pulse_start(s_cyc);
    idle(120);
    lat = last_cs_fall - s_cyc - 1;
    check("ss_latency_1to4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    check("ss_frames", frames - f0, 1);
    check("ss_cs_low_len", low_len, 68);
    check("ss_falls_cs_low", fall_cs_low - fl0, 17);
    check("ss_frame_done", done_cnt - d0, 1);
    check("ss_done_align", bad_done, 0);
    check("ss_busy_drop", busy_low_after, 14);
    check("ss_busy_end", {31'd0, busy}, 32'd0);

    // Back-to-back: second request held through FRAME and QUIET.
    f0 = frames; o0 = ovr_cnt;
    pulse_start(s_cyc);
    idle(20);
    pulse_start(s_cyc);
    idle(200);
    check("b2b_frames", frames - f0, 2);
    check("b2b_gap", high_gap, 16);
    check("b2b_low_len", low_len, 68);
    check("b2b_overrun", ovr_cnt - o0, 0);

    // Overrun: the third request within one frame is dropped.
    f0 = frames; o0 = ovr_cnt;
    pulse_start(s_cyc);
    idle(20);
    pulse_start(s_cyc);
    idle(20);
    pulse_start(s_cyc);
    idle(220);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_frames", frames - f0, 2);
    check("ovr_done_align", bad_done, 0);

    // Continuous: 1000 enabled edges give 10 timer requests.
    f0 = frames; o0 = ovr_cnt;
    @(negedge clk); #1;
    en = 1'b1;
    idle(1000);
    en = 1'b0;
    idle(200);
    check("cont_spacing", fall_gap, 100);
    check("cont_overrun", ovr_cnt - o0, 0);
    idle(300);
    check("cont_frames_stop", frames - f0, 10);
    check("cont_idle", {31'd0, busy}, 32'd0);

    // Reset after the 8th fall tick of a frame.
    f0 = frames; d0 = done_cnt; fl0 = fall_cs_low;
    pulse_start(s_cyc);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (fall_cs_low - fl0 == 8) hit = 1'b1;
    end
    check("mid_reached_8", {31'd0, hit}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_async_cs_sclk", {30'd0, CS, SCLK}, 32'd3);
    check("mid_async_busy", {31'd0, busy}, 32'd0);
    idle(3);
    check("mid_no_done", done_cnt - d0, 0);
    reset = 1'b1;
    fl0 = fall_cs_low;
    pulse_start(s_cyc);
    idle(120);
    check("mid_fresh_falls", fall_cs_low - fl0, 17);
    check("mid_fresh_low", low_len, 68);
    check("mid_fresh_frames", frames - f0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
